// File: rtl/demux_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module   : demux_stream_pkg
// Brief    : Shared defaults and helper functions for the 1:N stream demux.
// Revision : 1.0 - initial release
// ============================================================================
package demux_stream_pkg;

    localparam int c_def_sel_w  = 3;
    localparam int c_def_data_w = 8;
    localparam int c_def_cnt_w  = 16;

    function automatic int num_ch(input int sel_w);
        return 1 << sel_w;
    endfunction

    // Saturating increment for counters up to 31 bits wide.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
        logic [31:0] v_max;
        v_max = (32'd1 << w) - 32'd1;
        return (v == v_max) ? v : v + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/demux_stream_slot.sv
`default_nettype none
// ============================================================================
// Module   : demux_stream_slot
// Brief    : One-entry output buffer for a single demux channel; optional
//            drain counter when DEMUX_STREAM_CNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module demux_stream_slot
    import demux_stream_pkg::*;
#(
    parameter int DATA_W = c_def_data_w
`ifdef DEMUX_STREAM_CNT_EN
   ,parameter int CNT_W  = c_def_cnt_w
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
`ifdef DEMUX_STREAM_CNT_EN
   ,output logic [CNT_W-1:0]  o_cnt
`endif
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic              w_drain;

    assign w_drain = r_valid & i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    // A load wins over a drain so a same-cycle drain+reload keeps valid high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (w_drain) begin
            r_valid <= 1'b0;
        end
    end

`ifdef DEMUX_STREAM_CNT_EN
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_drain) begin
            r_cnt <= CNT_W'(sat_inc(32'(r_cnt), CNT_W));
        end
    end

    assign o_cnt = r_cnt;
`endif

endmodule
`default_nettype wire

// File: rtl/demux_stream_1n.sv
`default_nettype none
// ============================================================================
// Module   : demux_stream_1n
// Brief    : 1:2^SEL_W streaming demux with per-channel one-entry buffers and
//            round-robin auto-select. DEMUX_STREAM_CNT_EN adds drain counters.
// Revision : 1.0 - initial release
// ============================================================================
module demux_stream_1n
    import demux_stream_pkg::*;
#(
    parameter int SEL_W  = c_def_sel_w,
    parameter int DATA_W = c_def_data_w
`ifdef DEMUX_STREAM_CNT_EN
   ,parameter int CNT_W  = c_def_cnt_w
`endif
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_W-1:0]                in_data,
    input  logic [SEL_W-1:0]                 in_sel,
    input  logic                             auto_mode,
    output logic [SEL_W-1:0]                 cur_sel,
    output logic [num_ch(SEL_W)-1:0]         out_valid,
    input  logic [num_ch(SEL_W)-1:0]         out_ready,
    output logic [num_ch(SEL_W)*DATA_W-1:0]  out_data
`ifdef DEMUX_STREAM_CNT_EN
   ,output logic [num_ch(SEL_W)*CNT_W-1:0]   out_cnt
`endif
);

    localparam int c_n = num_ch(SEL_W);

    logic [SEL_W-1:0] r_ptr;
    logic [SEL_W-1:0] w_tgt;
    logic             w_accept;

    assign w_tgt    = auto_mode ? r_ptr : in_sel;
    // Combinational ready from the target consumer keeps full throughput.
    assign in_ready = !out_valid[w_tgt] || out_ready[w_tgt];
    assign w_accept = in_valid && in_ready;
    assign cur_sel  = r_ptr;

    // Natural SEL_W-bit wrap gives modulo-N advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_accept && auto_mode) begin
            r_ptr <= r_ptr + SEL_W'(1);
        end
    end

    for (genvar k = 0; k < c_n; k++) begin : g_slot
        logic w_load;

        assign w_load = w_accept && (w_tgt == SEL_W'(k));

        demux_stream_slot #(
            .DATA_W (DATA_W)
`ifdef DEMUX_STREAM_CNT_EN
           ,.CNT_W  (CNT_W)
`endif
        ) u_slot (
            .clk     (clk),
            .rst     (rst),
            .i_load  (w_load),
            .i_data  (in_data),
            .i_ready (out_ready[k]),
            .o_valid (out_valid[k]),
            .o_data  (out_data[k*DATA_W +: DATA_W])
`ifdef DEMUX_STREAM_CNT_EN
           ,.o_cnt   (out_cnt[k*CNT_W +: CNT_W])
`endif
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_demux_stream_1n.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux_stream_1n
// Brief    : Directed table-driven bench for demux_stream_1n.
// Revision : 1.0 - initial release
// ============================================================================
module tb_demux_stream_1n;

    localparam int c_sel_w  = 3;
    localparam int c_data_w = 8;
    localparam int c_n      = 8;
`ifdef DEMUX_STREAM_CNT_EN
    localparam int c_cnt_w  = 2;
`endif

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic [c_data_w-1:0]      in_data = '0;
    logic [c_sel_w-1:0]       in_sel = '0;
    logic                     auto_mode = 1'b0;
    logic [c_sel_w-1:0]       cur_sel;
    logic [c_n-1:0]           out_valid;
    logic [c_n-1:0]           out_ready = '0;
    logic [c_n*c_data_w-1:0]  out_data;
`ifdef DEMUX_STREAM_CNT_EN
    logic [c_n*c_cnt_w-1:0]   out_cnt;
`endif

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    demux_stream_1n #(
        .SEL_W  (c_sel_w),
        .DATA_W (c_data_w)
`ifdef DEMUX_STREAM_CNT_EN
       ,.CNT_W  (c_cnt_w)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .auto_mode (auto_mode),
        .cur_sel   (cur_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef DEMUX_STREAM_CNT_EN
       ,.out_cnt   (out_cnt)
`endif
    );

    typedef struct {
        logic       am;
        logic [2:0] sel;
        logic       vld;
        logic [7:0] din;
        logic [7:0] ordy;
        logic       exp_rdy;
        logic [7:0] exp_ov;
        logic [2:0] exp_cs;
        int         ch;
        logic [7:0] exp_d;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            n_pass++;
    endtask

    function automatic logic [7:0] ch_data(input int ch);
        return out_data[ch*c_data_w +: c_data_w];
    endfunction

    task automatic add(input logic am, input logic [2:0] sel, input logic vld,
                       input logic [7:0] din, input logic [7:0] ordy, input logic exp_rdy,
                       input logic [7:0] exp_ov, input logic [2:0] exp_cs,
                       input int ch, input logic [7:0] exp_d);
        vec_t v;
        v.am = am; v.sel = sel; v.vld = vld; v.din = din; v.ordy = ordy;
        v.exp_rdy = exp_rdy; v.exp_ov = exp_ov; v.exp_cs = exp_cs;
        v.ch = ch; v.exp_d = exp_d;
        vecs.push_back(v);
    endtask

    initial begin
        // Manual routing to channel 5, stall, then drain+reload.
        add(0, 5, 1, 8'hA5, 8'h00, 1, 8'h20, 0, 5, 8'hA5);
        add(0, 5, 1, 8'h5A, 8'h00, 0, 8'h20, 0, 5, 8'hA5);
        add(0, 5, 1, 8'h5A, 8'h20, 1, 8'h20, 0, 5, 8'h5A);
        add(0, 5, 0, 8'h00, 8'h20, 1, 8'h00, 0, 5, 8'h5A);
        // Round-robin burst of ten words with every consumer ready.
        for (int i = 0; i < 10; i++)
            add(1, 0, 1, 8'(i), 8'hFF, 1, 8'(1 << (i % 8)), 3'((i + 1) % 8), i % 8, 8'(i));
        add(1, 0, 0, 8'h00, 8'hFF, 1, 8'h00, 2, 1, 8'h09);
        // Fill channel 2 manually, then stall auto mode on it.
        add(0, 2, 1, 8'h77, 8'hFB, 1, 8'h04, 2, 2, 8'h77);
        add(1, 0, 1, 8'h88, 8'hFB, 0, 8'h04, 2, 2, 8'h77);
        add(1, 0, 1, 8'h88, 8'hFB, 0, 8'h04, 2, 2, 8'h77);
        add(1, 0, 1, 8'h88, 8'hFF, 1, 8'h04, 3, 2, 8'h88);
        add(1, 0, 1, 8'h99, 8'hFF, 1, 8'h08, 4, 3, 8'h99);
        // Blocked target stalls input even though other channels are free.
        add(0, 0, 0, 8'h00, 8'h00, 1, 8'h08, 4, 3, 8'h99);
        add(0, 3, 1, 8'h11, 8'h00, 0, 8'h08, 4, 3, 8'h99);

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("reset out_valid", 32'(out_valid), 32'h00);
        check("reset cur_sel", 32'(cur_sel), 32'h0);
        check("reset in_ready", 32'(in_ready), 32'h1);
`ifdef DEMUX_STREAM_CNT_EN
        check("reset out_cnt", 32'(out_cnt), 32'h0);
`endif

        foreach (vecs[i]) begin
            auto_mode = vecs[i].am;
            in_sel    = vecs[i].sel;
            in_valid  = vecs[i].vld;
            in_data   = vecs[i].din;
            out_ready = vecs[i].ordy;
            #1;
            check($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
            @(posedge clk);
            #1;
            check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
            check($sformatf("v%0d cur_sel", i), 32'(cur_sel), 32'(vecs[i].exp_cs));
            check($sformatf("v%0d data ch%0d", i, vecs[i].ch), 32'(ch_data(vecs[i].ch)),
                  32'(vecs[i].exp_d));
        end

        // Fill channels 0..2 (channel 3 already holds data), then async reset.
        auto_mode = 1'b0;
        out_ready = 8'h00;
        for (int k = 0; k < 3; k++) begin
            in_sel   = 3'(k);
            in_valid = 1'b1;
            in_data  = 8'(8'h31 + k);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("prefill out_valid", 32'(out_valid), 32'h0F);
        check("prefill cur_sel", 32'(cur_sel), 32'h4);
        #3 rst = 1'b1;
        #1;
        check("async rst out_valid", 32'(out_valid), 32'h00);
        check("async rst cur_sel", 32'(cur_sel), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("post rst out_valid", 32'(out_valid), 32'h00);
        check("post rst data ch0", 32'(ch_data(0)), 32'h00);
        check("post rst data ch2", 32'(ch_data(2)), 32'h00);
        check("post rst in_ready", 32'(in_ready), 32'h1);

`ifdef DEMUX_STREAM_CNT_EN
        // Five drains on channel 0 saturate a 2-bit counter at 3.
        out_ready = 8'h01;
        in_sel    = 3'd0;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_data  = 8'(k);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("cnt ch0 saturated", 32'(out_cnt[0 +: c_cnt_w]), 32'h3);
        check("cnt others zero", 32'(out_cnt[c_n*c_cnt_w-1:c_cnt_w]), 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/demux_stream_1n.md
# demux_stream_1n

Parametrised 1:N streaming demultiplexer with a valid/ready handshake, one-entry output buffering per channel, and a round-robin auto-select mode. It generalises the fixed-width combinational 1:4 and 1:8 demultiplexers into a registered block that routes a DATA_W-bit stream to 2^SEL_W consumers. Each consumer can apply backpressure independently. It sits between a single producer and a bank of downstream channel consumers.

## Interface
- SEL_W, 3, select width; channel count N = 2^SEL_W
- DATA_W, 8, payload width
- CNT_W, 16, per-channel counter width (used only with DEMUX_STREAM_CNT_EN)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  producer has data
- in_ready  out  1  block accepts data this cycle
- in_data  in  DATA_W  payload
- in_sel  in  SEL_W  target channel when auto_mode=0
- auto_mode  in  1  1: target = internal round-robin pointer
- cur_sel  out  SEL_W  current round-robin pointer value
- out_valid  out  N  per-channel valid
- out_ready  in  N  per-channel ready
- out_data  out  N*DATA_W  flat; channel k occupies bits [k*DATA_W +: DATA_W]
- out_cnt  out  N*CNT_W  per-channel delivered count; present only with DEMUX_STREAM_CNT_EN

## Operation
- Target channel t = auto_mode ? ptr : in_sel.
- Each channel holds one slot consisting of a valid bit and a data register. out_valid[k] is the slot valid bit. out_data[k] is the slot data.
- in_ready = !out_valid[t] || out_ready[t]. This is a combinational path from out_ready[t] and the select inputs. It is intentional.
- Accept occurs when in_valid && in_ready. On accept, slot t loads in_data and out_valid[t] is set to 1.
- Drain occurs when out_valid[k] && out_ready[k]. On drain without a same-cycle reload, out_valid[k] clears.
- Drain and accept on the same slot in the same cycle: the slot reloads and out_valid stays 1. No bubble is inserted.
- Slots other than t are never written by an accept. They drain independently.
- out_data holds its last value after valid clears.
- ptr increments modulo N on each accept while auto_mode=1, wrapping N-1 to 0. It does not increment when there is no accept.
- ptr holds its value while auto_mode=0 and resumes from that value when auto_mode returns to 1.
- auto_mode and in_sel are sampled in the same cycle as the accept. There is no pipelining of the select.
- cur_sel = ptr.

## Timing
- Reset values: out_valid=0, out_data=0, ptr=0, out_cnt=0. in_ready follows its equation, so it evaluates to 1 after reset.
- Reset asserted mid-operation discards all buffered data immediately (asynchronous).
- Latency: data accepted on edge n appears as out_valid/out_data after edge n.
- Throughput is one transfer per cycle per channel while the consumer holds out_ready=1.
- A blocked target stalls the whole input, even if other channels are free. Routing is strictly in order.

## Configuration
- DEMUX_STREAM_CNT_EN
  - Defined: out_cnt exists. Counter k increments by 1 on each drain of channel k and saturates at 2^CNT_W−1 with no wrap. Reset value is 0.
  - Undefined: out_cnt and all counter logic are absent. Routing behaviour is identical in both cases.

## Structure
- Package demux_stream_pkg holds:
  - default SEL_W, DATA_W and CNT_W localparams
  - the channel-count function for 2^SEL_W
  - the saturating-increment function for the counters
- Sub-module demux_stream_slot implements a single one-entry buffer (load, drain, valid, data, optional counter). It is instantiated N times in a generate loop.
- The top level holds t selection, ptr, and in_ready.

## Test plan
- Reset with in_valid=0: out_valid=8'h00, cur_sel=0, in_ready=1. With the counter enabled, out_cnt is all zero.
- auto_mode=0, in_sel=5, in_data=8'hA5 for 1 cycle, all out_ready=0: out_valid=8'h20 and channel 5 data=8'hA5 one cycle later. A second send to channel 5 sees in_ready=0 and stalls. Raising out_ready[5] accepts it the same cycle and out_valid[5] stays 1.
- auto_mode=1, all out_ready=1, 10 back-to-back words 0..9: channel k receives k for k=0..7, then channel 0 receives 8 and channel 1 receives 9. cur_sel ends at 2.
- auto_mode=1 with out_ready[2]=0 and channel 2 already full: the stream stalls at ptr=2 and ptr does not advance. Releasing out_ready[2] resumes delivery.
- Assert rst while 3 slots are full: all out_valid drop asynchronously, ptr=0, and no stale data appears after reset deasserts.
- With DEMUX_STREAM_CNT_EN and CNT_W=2: 5 drains on channel 0 give out_cnt[0]=3 (saturated), while the other channels stay at 0.
